// File: rtl/multi_cycle_control_pkg.sv
// rtl/multi_cycle_control_pkg.sv - opcodes, FSM states and control encodings for the MIPS multi-cycle controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_BR = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_alu_op(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDIU) || (op == OP_ANDI) ||
           (op == OP_AND) || (op == OP_ORI) || (op == OP_OR) || (op == OP_SLL) ||
           (op == OP_SLTI);
  endfunction

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  function automatic logic is_ls_op(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

  // Opcodes that leave ID without retiring; anything else at ID is a NOP or j.
  function automatic logic stays_busy(input logic [5:0] op);
    return is_alu_op(op) || is_branch_op(op) || is_ls_op(op) || (op == OP_HALT);
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_SLL:          return ALU_SLL;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_SLTI:         return ALU_SLT;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// rtl/multi_cycle_control_if.sv - controller <-> datapath bundle
interface multi_cycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opCode;
  logic             zero;
  logic             sign;
  logic             PCWre;
  logic             IRWre;
  logic             InsMemRW;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic             ExtSel;
  logic             RegDst;
  logic             RegWre;
  logic             DBDataSrc;
  logic             mRD;
  logic             mWR;
  logic [1:0]       PCSrc;
  logic [2:0]       ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [CNT_W-1:0] cycle_cnt;

  modport master (
    input  opCode, zero, sign,
    output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegDst, RegWre,
           DBDataSrc, mRD, mWR, PCSrc, ALUOp, state, instr_cnt, cycle_cnt
  );

  modport slave (
    output opCode, zero, sign,
    input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, RegDst, RegWre,
           DBDataSrc, mRD, mWR, PCSrc, ALUOp, state, instr_cnt, cycle_cnt
  );
endinterface

// File: rtl/multi_cycle_control_decode.sv
// rtl/multi_cycle_control_decode.sv - combinational control decode from (state, opcode, flags)
module mc_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       sign_i,
  input  logic       kill_i,
  output logic       pc_wre_o,
  output logic       ir_wre_o,
  output logic       ins_mem_rw_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       ext_sel_o,
  output logic       reg_dst_o,
  output logic       reg_wre_o,
  output logic       db_data_src_o,
  output logic       mrd_o,
  output logic       mwr_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o
);
  logic taken;

  always_comb begin
    pc_wre_o      = 1'b0;
    ir_wre_o      = 1'b0;
    ins_mem_rw_o  = 1'b1;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 1'b0;
    ext_sel_o     = 1'b0;
    reg_dst_o     = 1'b0;
    reg_wre_o     = 1'b0;
    db_data_src_o = 1'b0;
    mrd_o         = 1'b0;
    mwr_o         = 1'b0;
    pc_src_o      = PC_NEXT;
    alu_op_o      = ALU_ADD;
    taken         = 1'b0;
    case (state_i)
      S_IF: ir_wre_o = 1'b1;
      S_ID: begin
        if (op_i == OP_J) begin
          pc_src_o = PC_JUMP;
          pc_wre_o = 1'b1;
        end else if (!stays_busy(op_i)) begin
          pc_wre_o = 1'b1;
        end
      end
      S_EXE_AL: begin
        alu_op_o    = alu_op_of(op_i);
        alu_src_a_o = (op_i == OP_SLL);
        alu_src_b_o = (op_i == OP_ADDIU) || (op_i == OP_ANDI) || (op_i == OP_ORI) ||
                      (op_i == OP_SLTI);
        ext_sel_o   = !((op_i == OP_ANDI) || (op_i == OP_ORI) || (op_i == OP_SLL));
      end
      S_WB_AL: begin
        reg_wre_o = 1'b1;
        reg_dst_o = (op_i == OP_ADD) || (op_i == OP_SUB) || (op_i == OP_AND) ||
                    (op_i == OP_OR) || (op_i == OP_SLL);
        pc_wre_o  = 1'b1;
      end
      S_EXE_BR: begin
        alu_op_o = (op_i == OP_BLTZ) ? ALU_SLT : ALU_SUB;
        case (op_i)
          OP_BEQ:  taken = zero_i;
          OP_BNE:  taken = !zero_i;
          OP_BLTZ: taken = sign_i;
          default: taken = 1'b0;
        endcase
        pc_src_o = taken ? PC_BRANCH : PC_NEXT;
        pc_wre_o = 1'b1;
      end
      S_EXE_LS: begin
        alu_src_b_o = 1'b1;
        ext_sel_o   = 1'b1;
      end
      S_MEM: begin
        if (op_i == OP_SW) begin
          mwr_o    = 1'b1;
          pc_wre_o = 1'b1;
        end else if (op_i == OP_LW) begin
          mrd_o = 1'b1;
        end
      end
      S_WB_LD: begin
        reg_wre_o     = 1'b1;
        db_data_src_o = 1'b1;
        mrd_o         = 1'b1;
        pc_wre_o      = 1'b1;
      end
      default: ;
    endcase
    // Reset cycle: suppress every enable even if the state is mid-instruction.
    if (kill_i) begin
      pc_wre_o  = 1'b0;
      ir_wre_o  = 1'b0;
      reg_wre_o = 1'b0;
      mrd_o     = 1'b0;
      mwr_o     = 1'b0;
    end
  end
endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle MIPS controller: state register, sequencing, counters
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  multi_cycle_control_if.master bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             pc_wre;

  mc_decode u_decode (
    .state_i       (state_q),
    .op_i          (bus.opCode),
    .zero_i        (bus.zero),
    .sign_i        (bus.sign),
    .kill_i        (rst),
    .pc_wre_o      (pc_wre),
    .ir_wre_o      (bus.IRWre),
    .ins_mem_rw_o  (bus.InsMemRW),
    .alu_src_a_o   (bus.ALUSrcA),
    .alu_src_b_o   (bus.ALUSrcB),
    .ext_sel_o     (bus.ExtSel),
    .reg_dst_o     (bus.RegDst),
    .reg_wre_o     (bus.RegWre),
    .db_data_src_o (bus.DBDataSrc),
    .mrd_o         (bus.mRD),
    .mwr_o         (bus.mWR),
    .pc_src_o      (bus.PCSrc),
    .alu_op_o      (bus.ALUOp)
  );

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        if (bus.opCode == OP_HALT)          state_d = S_HALT;
        else if (is_branch_op(bus.opCode))  state_d = S_EXE_BR;
        else if (is_ls_op(bus.opCode))      state_d = S_EXE_LS;
        else if (is_alu_op(bus.opCode))     state_d = S_EXE_AL;
        else                                state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (bus.opCode == OP_LW) ? S_WB_LD : S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_comb begin
    instr_cnt_d = instr_cnt_q + {{(CNT_W-1){1'b0}}, pc_wre};
    cycle_cnt_d = (state_q == S_HALT) ? cycle_cnt_q : cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IF;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign bus.PCWre     = pc_wre;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;
  assign bus.cycle_cnt = cycle_cnt_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - self-checking bench for multi_cycle_control
module tb_multi_cycle_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_cycle_control_if #(.CNT_W(32)) bus ();
  multi_cycle_control #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int unsigned m_instr = 0;
  int unsigned m_cyc = 0;
  int lat[7] = '{2, 2, 3, 4, 4, 5, 2};

  // 0 nop, 1 j, 2 branch, 3 alu, 4 sw, 5 lw, 6 halt
  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'b111000: return 1;
      6'b111111: return 6;
      6'b110000, 6'b110001, 6'b110010: return 2;
      6'b100110: return 4;
      6'b100111: return 5;
      6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010, 6'b010011,
      6'b011000, 6'b011100: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_state(input int c, input int k);
    if (k == 0) return 0;
    if (k == 1) return 1;
    if (c == 2) return 3;
    if (c == 3) return (k == 2) ? 2 : 6;
    if (k == 2) return 4;
    if (k == 3) return 5;
    return 7;
  endfunction

  function automatic int exp_aluop(input logic [5:0] op);
    case (op)
      6'b000001: return 1;
      6'b011000: return 2;
      6'b010010, 6'b010011: return 3;
      6'b010000, 6'b010001: return 4;
      6'b011100: return 6;
      default: return 0;
    endcase
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic z, input logic s, input int abort_at);
    int c;
    int n;
    logic last;
    logic taken;
    logic [3:0] es;
    logic [8:0] got;
    logic [8:0] exp;
    c = op_class(op);
    n = lat[c];
    taken = (op == 6'b110000) ? z : (op == 6'b110001) ? !z : (op == 6'b110010) ? s : 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.opCode = op;
      bus.zero = z;
      bus.sign = s;
      es = 4'(exp_state(c, k));
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.mWR, bus.mRD} !== {es, 5'b0}) begin
          failures++;
          $display("FAIL abort_cycle op=%b got=%h exp=%h", op,
                   {bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.mWR, bus.mRD}, {es, 5'b0});
        end
        @(posedge clk);
        m_instr = 0;
        m_cyc = 0;
        return;
      end
      rst = 1'b0;
      #1;
      last = (k == n - 1);
      exp = {es, last && c != 6, k == 0, last && (c == 3 || c == 5), last && c == 4, c == 5 && k >= 3};
      got = {bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.mWR, bus.mRD};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL ctrl op=%b k=%0d got=%h exp=%h", op, k, got, exp);
      end
      checks++;
      if (bus.instr_cnt !== m_instr || bus.cycle_cnt !== m_cyc) begin
        failures++;
        $display("FAIL counters op=%b k=%0d got=%0d/%0d exp=%0d/%0d", op, k,
                 bus.instr_cnt, bus.cycle_cnt, m_instr, m_cyc);
      end
      if (last && c != 6) begin
        checks++;
        if (bus.PCSrc !== ((c == 1) ? 2'b10 : (c == 2 && taken) ? 2'b01 : 2'b00)) begin
          failures++;
          $display("FAIL pcsrc op=%b z=%b s=%b got=%b", op, z, s, bus.PCSrc);
        end
      end
      if (es == 2) begin
        checks++;
        if ({bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel} !==
            {3'(exp_aluop(op)), op == 6'b011000,
             op == 6'b000010 || op == 6'b010000 || op == 6'b010010 || op == 6'b011100,
             !(op == 6'b010000 || op == 6'b010010 || op == 6'b011000)}) begin
          failures++;
          $display("FAIL exe_al op=%b got=%b_%b%b%b", op, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel);
        end
      end
      if (es == 3) begin
        checks++;
        if (bus.ALUOp !== ((op == 6'b110010) ? 3'b110 : 3'b001)) begin
          failures++;
          $display("FAIL exe_br_aluop op=%b got=%b", op, bus.ALUOp);
        end
      end
      if (es == 4) begin
        checks++;
        if ({bus.ALUOp, bus.ALUSrcB, bus.ExtSel} !== 5'b000_1_1) begin
          failures++;
          $display("FAIL exe_ls got=%b_%b%b exp=000_11", bus.ALUOp, bus.ALUSrcB, bus.ExtSel);
        end
      end
      if (es == 6 || es == 7) begin
        checks++;
        if ({bus.RegDst, bus.DBDataSrc} !==
            ((es == 7) ? 2'b01 : {op == 6'b000000 || op == 6'b000001 || op == 6'b010001 ||
                                  op == 6'b010011 || op == 6'b011000, 1'b0})) begin
          failures++;
          $display("FAIL writeback op=%b got RegDst=%b DBDataSrc=%b", op, bus.RegDst, bus.DBDataSrc);
        end
      end
      checks++;
      if ((bus.RegWre & bus.mWR) !== 1'b0 || bus.InsMemRW !== 1'b1) begin
        failures++;
        $display("FAIL invariant op=%b RegWre=%b mWR=%b InsMemRW=%b", op, bus.RegWre, bus.mWR, bus.InsMemRW);
      end
      m_cyc++;
      if (last && c != 6) m_instr++;
    end
  endtask

  task automatic check_retired(input string tag);
    #5;
    checks++;
    if (bus.instr_cnt !== m_instr) begin
      failures++;
      $display("FAIL %s instr_cnt got=%0d exp=%0d", tag, bus.instr_cnt, m_instr);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.opCode = 6'b000000;
    bus.zero = 1'b0;
    bus.sign = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus.state, bus.PCWre, bus.IRWre, bus.RegWre, bus.mWR, bus.instr_cnt, bus.cycle_cnt} !== 72'd0) begin
      failures++;
      $display("FAIL reset state=%0d PCWre=%b IRWre=%b instr=%0d cyc=%0d", bus.state, bus.PCWre,
               bus.IRWre, bus.instr_cnt, bus.cycle_cnt);
    end
    m_instr = 0;
    m_cyc = 0;
  endtask

  task automatic test_add;
    run_instr(6'b000000, 1'b0, 1'b0, -1);
    check_retired("add_retire");
  endtask

  task automatic test_lw;
    run_instr(6'b100111, 1'b0, 1'b0, -1);
  endtask

  task automatic test_branch;
    run_instr(6'b110000, 1'b1, 1'b0, -1);
    run_instr(6'b110000, 1'b0, 1'b0, -1);
    run_instr(6'b110010, 1'b0, 1'b1, -1);
    run_instr(6'b110001, 1'b1, 1'b1, -1);
  endtask

  task automatic test_jump;
    run_instr(6'b111000, 1'b0, 1'b0, -1);
    check_retired("jump_retire");
  endtask

  task automatic test_reset_mid_sw;
    run_instr(6'b100110, 1'b0, 1'b0, 3);
    run_instr(6'b101010, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random;
    logic [5:0] ops[14] = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                           6'b010011, 6'b011000, 6'b011100, 6'b100110, 6'b100111, 6'b110000,
                           6'b110001, 6'b111000};
    logic [5:0] op;
    int idx;
    for (int i = 0; i < 40; i++) begin
      idx = int'($urandom_range(0, 16));
      if (idx < 14) op = ops[idx];
      else op = 6'($urandom_range(0, 63));
      if (op == 6'b111111) op = 6'b101010;
      if (i == 25) op = 6'b110010;
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_halt;
    run_instr(6'b111111, 1'b0, 1'b0, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.state !== 4'd8 || bus.PCWre !== 1'b0 || bus.cycle_cnt !== m_cyc || bus.instr_cnt !== m_instr) begin
        failures++;
        $display("FAIL halt_hold i=%0d state=%0d PCWre=%b cyc=%0d exp_cyc=%0d instr=%0d exp_instr=%0d", i,
                 bus.state, bus.PCWre, bus.cycle_cnt, m_cyc, bus.instr_cnt, m_instr);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.instr_cnt !== 0 || bus.cycle_cnt !== 0) begin
      failures++;
      $display("FAIL halt_reset state=%0d instr=%0d cyc=%0d", bus.state, bus.instr_cnt, bus.cycle_cnt);
    end
    m_instr = 0;
    m_cyc = 0;
    run_instr(6'b000001, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_branch();
    test_jump();
    test_reset_mid_sw();
    test_random();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
